// File: rtl/cacheline_adaptor.sv
// Cache-line to DRAM burst adaptor: one line request becomes BEATS beats on the memory port.
// Reads assemble beats little-endian into line_o; writes slice the latched line into beats.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_line_rd;
    logic [LINE_W-1:0]  r_line_wr;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] w_burst;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (write_i)     w_next = WRITE;
                else if (read_i) w_next = READ;
            end
            READ, WRITE: begin
                if (resp_i && r_cnt == LAST) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Beat mux driven straight from the counter so each DRAM strobe sees the current slice.
    always_comb begin
        w_burst = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) w_burst = r_line_wr[b*BURST_W +: BURST_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_line_rd <= '0;
            r_line_wr <= '0;
            r_addr    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (write_i || read_i) begin
                        r_addr <= address_i & ~OFF_MASK;
                        r_cnt  <= '0;
                        if (write_i) r_line_wr <= line_i;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (r_cnt == CNT_W'(b)) r_line_rd[b*BURST_W +: BURST_W] <= burst_i;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign line_o    = r_line_rd;
    assign address_o = r_addr;
    assign burst_o   = w_burst;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected beats/lines/addresses queued at stimulus
// time, consumed when the DUT presents a write beat or a completion pulse.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_checks = 0;
    int n_errors = 0;
    int n_resp   = 0;
    bit seen_read_o;

    logic [63:0]  exp_beat[$];
    logic [255:0] exp_line[$];
    logic [31:0]  exp_addr[$];
    logic [255:0] m_line;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (read_o) seen_read_o = 1'b1;
        if (write_o && resp_i) begin
            if (exp_beat.size() == 0) check_val("beat_unexpected", 1, 0);
            else check_val("burst_o", burst_o, exp_beat.pop_front());
        end
        if (resp_o) begin
            n_resp++;
            if (exp_line.size() == 0) check_val("resp_unexpected", 1, 0);
            else begin
                check_val("line_o", line_o, exp_line.pop_front());
                check_val("address_o", address_o, exp_addr.pop_front());
            end
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input int gap_after, input int gap_len);
        address_i = addr;
        read_i    = 1'b1;
        exp_line.push_back(line);
        exp_addr.push_back(addr & ~32'h1F);
        tick();
        check_val("rd_read_o_rise", read_o, 1);
        address_i = 32'hFFFF_FFFF;
        for (int b = 0; b < 4; b++) begin
            resp_i  = 1'b1;
            burst_i = line[b*64 +: 64];
            tick();
            if (b == gap_after) begin
                resp_i  = 1'b0;
                burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
                for (int g = 0; g < gap_len; g++) begin
                    check_val("rd_gap_resp_o", resp_o, 0);
                    tick();
                end
            end
        end
        resp_i = 1'b0;
        check_val("rd_resp_o", resp_o, 1);
        check_val("rd_read_o_drop", read_o, 0);
        read_i = 1'b0;
        m_line = line;
        tick();
        check_val("rd_resp_o_pulse", resp_o, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit also_read);
        address_i = addr;
        line_i    = line;
        write_i   = 1'b1;
        read_i    = also_read;
        seen_read_o = 1'b0;
        for (int b = 0; b < 4; b++) exp_beat.push_back(line[b*64 +: 64]);
        exp_line.push_back(m_line);
        exp_addr.push_back(addr & ~32'h1F);
        tick();
        check_val("wr_write_o_rise", write_o, 1);
        line_i    = ~line;
        address_i = 32'h0;
        for (int b = 0; b < 4; b++) begin
            resp_i = 1'b1;
            tick();
        end
        resp_i = 1'b0;
        check_val("wr_resp_o", resp_o, 1);
        check_val("wr_write_o_drop", write_o, 0);
        write_i = 1'b0;
        read_i  = 1'b0;
        tick();
        check_val("wr_resp_o_pulse", resp_o, 0);
    endtask

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
        burst_i = '0; resp_i = 0; m_line = '0;
        tick();
        tick();
        check_val("rst_read_o", read_o, 0);
        check_val("rst_write_o", write_o, 0);
        check_val("rst_resp_o", resp_o, 0);
        check_val("rst_line_o", line_o, 0);
        check_val("rst_burst_o", burst_o, 0);
        check_val("rst_address_o", address_o, 0);
        rst = 1'b0;
        tick();

        // 1: plain read
        do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, -1, 0);

        // 2: plain write; line_o must keep the read result
        do_write(32'h8000_003F, {64'hD3D3_0003_D3D3_0003, 64'hD2D2_0002_D2D2_0002,
                                 64'hD1D1_0001_D1D1_0001, 64'hD0D0_0000_D0D0_0000}, 1'b0);

        // 3: read with a two-cycle strobe gap after beat 1
        do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1, 2);

        // 4: read and write requested together, write wins
        do_write(32'h0000_2040, {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                                 64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000}, 1'b1);
        check_val("both_read_o_seen", {255'b0, seen_read_o}, 0);

        // 5: reset during beat 2 of a read
        address_i = 32'h0000_0040;
        read_i    = 1'b1;
        tick();
        resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0000; tick();
        burst_i = 64'hAAAA_1111_0000_0000; tick();
        burst_i = 64'hAAAA_2222_0000_0000; rst = 1'b1; tick();
        check_val("abort_read_o", read_o, 0);
        check_val("abort_resp_o", resp_o, 0);
        check_val("abort_line_o", line_o, 0);
        rst = 1'b0; read_i = 1'b0; resp_i = 1'b0; m_line = '0;
        tick();
        check_val("abort_idle_resp_o", resp_o, 0);
        do_read(32'h0000_0047, {64'h0BEE_F003_0000_0000, 64'h0BEE_F002_0000_0000,
                                64'h0BEE_F001_0000_0000, 64'h0BEE_F000_0000_0000}, -1, 0);

        // 6: back-to-back read then write with a stray strobe while idle
        do_read(32'h0001_0010, {64'h5555_0003_5555_0003, 64'h5555_0002_5555_0002,
                                64'h5555_0001_5555_0001, 64'h5555_0000_5555_0000}, -1, 0);
        resp_i = 1'b1; burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        resp_i = 1'b0;
        check_val("stray_read_o", read_o, 0);
        check_val("stray_write_o", write_o, 0);
        check_val("stray_line_o", line_o, m_line);
        do_write(32'h0001_0020, {64'h6666_0003_6666_0003, 64'h6666_0002_6666_0002,
                                 64'h6666_0001_6666_0001, 64'h6666_0000_6666_0000}, 1'b0);

        tick();
        check_val("beats_left", exp_beat.size(), 0);
        check_val("lines_left", exp_line.size(), 0);
        check_val("resp_count", n_resp, 7);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
